keypad_scanner: RTL and testbench

//  Reads a 4x4 matrix keypad for operator entry (irrigation mode/time settings). Counterpart of the
//  LED-matrix row/column writer: drives one column low at a time and samples rows.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_scanner_if.sv | 33 +++
 rtl/scan_timer.sv | 36 +++
 rtl/keypad_scanner.sv | 168 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
// Purpose: FSM state encoding, key index-to-legend map, idle column drive.
// Ports: none (package).
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    // Column 0 driven low out of reset.
    localparam logic [3:0] COL_IDLE = 4'b1110;

    // Key index is {row[1:0], col[1:0]}; standard 4x4 telephone-style legend.
    localparam logic [3:0] KEY_1    = 4'd0;
    localparam logic [3:0] KEY_2    = 4'd1;
    localparam logic [3:0] KEY_3    = 4'd2;
    localparam logic [3:0] KEY_A    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_B    = 4'd7;
    localparam logic [3:0] KEY_7    = 4'd8;
    localparam logic [3:0] KEY_8    = 4'd9;
    localparam logic [3:0] KEY_9    = 4'd10;
    localparam logic [3:0] KEY_C    = 4'd11;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_0    = 4'd13;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    // Active-low one-hot drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key-event signal bundle
// Purpose: groups the matrix drive/sense lines and the key event outputs.
// Signals: rows_i (active-low rows), columns_o (active-low column drive),
//          key_valid, key_code, key_held, multiple_err.
// Modports: master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;

    logic [3:0] rows_i;
    logic [3:0] columns_o;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       multiple_err;

    modport master (
        input  rows_i,
        output columns_o,
        output key_valid,
        output key_code,
        output key_held,
        output multiple_err
    );

    modport slave (
        output rows_i,
        input  columns_o,
        input  key_valid,
        input  key_code,
        input  key_held,
        input  multiple_err
    );

endinterface

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - column slot timer and rotation for the keypad scan
// Purpose: counts SCAN_DIV cycles per column slot and rotates the column index.
// Ports: clk, rst (sync active-high), col (current column 0..3),
//        slot_end (last cycle of a slot), frame_end (last cycle of column 3).
module scan_timer #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] col,
    output logic       slot_end,
    output logic       frame_end
);

    localparam int SW = $clog2(SCAN_DIV);

    logic [SW-1:0] slot_q;
    logic [1:0]    col_q;

    assign slot_end  = (slot_q == SW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (col_q == 2'd3);
    assign col       = col_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            col_q  <= 2'd0;
        end else if (slot_end) begin
            slot_q <= '0;
            col_q  <= col_q + 2'd1;
        end else begin
            slot_q <= slot_q + SW'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and multi-key reject
// Purpose: scans columns, snapshots rows per frame, debounces press/release and
//          emits one-cycle key events.
// Ports: clk_50mhz (clock), init_pulse (sync active-high reset),
//        kp (keypad_scanner_if.master: rows_i in, columns_o/key_* out).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk_50mhz,
    input  logic              init_pulse,
    keypad_scanner_if.master  kp
);

    localparam int                AW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [AW-1:0]     LIM = AW'(DEBOUNCE_SCANS - 1);

    logic [1:0]  col;
    logic        slot_end;
    logic        frame_end;

    scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .clk       (clk_50mhz),
        .rst       (init_pulse),
        .col       (col),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    assign kp.columns_o = col_drive(col);

    // Rows idle high (pull-ups), so the synchronizer resets to "no key".
    logic [3:0]  rows_meta, rows_sync;
    logic [15:0] snap_q;
    logic        eval_q;

    always_ff @(posedge clk_50mhz) begin
        if (init_pulse) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
            snap_q    <= '0;
            eval_q    <= 1'b0;
        end else begin
            rows_meta <= kp.rows_i;
            rows_sync <= rows_meta;
            eval_q    <= frame_end;
            // Eval never coincides with a slot end (SCAN_DIV >= 4), so clearing
            // here cannot drop a column sample.
            if (eval_q) begin
                snap_q <= '0;
            end else if (slot_end) begin
                for (int r = 0; r < 4; r++) begin
                    snap_q[{r[1:0], col}] <= ~rows_sync[r];
                end
            end
        end
    end

    // Key count saturates at 2 ("more than one"); idx is the lowest key down.
    logic [1:0] nkeys;
    logic [3:0] idx;

    always_comb begin
        nkeys = 2'd0;
        idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_q[i]) begin
                if (nkeys == 2'd0) idx = 4'(i);
                if (nkeys != 2'd2) nkeys = nkeys + 2'd1;
            end
        end
    end

    state_t        state_q, state_n;
    logic [3:0]    cand_q, cand_n;
    logic [AW-1:0] agree_q, agree_n;
    logic [AW-1:0] rel_q, rel_n;
    logic [3:0]    code_q, code_n;
    logic          err_q, err_n;
    logic          accept;

    always_ff @(posedge clk_50mhz) begin
        if (init_pulse) begin
            state_q <= ST_IDLE;
            cand_q  <= 4'd0;
            agree_q <= '0;
            rel_q   <= '0;
            code_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cand_q  <= cand_n;
            agree_q <= agree_n;
            rel_q   <= rel_n;
            code_q  <= code_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cand_n  = cand_q;
        agree_n = agree_q;
        rel_n   = rel_q;
        code_n  = code_q;
        err_n   = err_q;
        accept  = 1'b0;
        if (eval_q) begin
            err_n = (nkeys == 2'd2);
            case (state_q)
                ST_IDLE: begin
                    if (nkeys == 2'd1) begin
                        cand_n  = idx;
                        agree_n = AW'(1);
                        if (LIM == '0) begin
                            accept  = 1'b1;
                            code_n  = idx;
                            rel_n   = '0;
                            state_n = ST_PRESSED;
                        end else begin
                            state_n = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (nkeys == 2'd1 && idx == cand_q) begin
                        if (agree_q >= LIM) begin
                            accept  = 1'b1;
                            code_n  = cand_q;
                            rel_n   = '0;
                            state_n = ST_PRESSED;
                        end else begin
                            agree_n = agree_q + AW'(1);
                        end
                    end else if (nkeys == 2'd1) begin
                        cand_n  = idx;
                        agree_n = AW'(1);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (nkeys == 2'd0) begin
                        if (rel_q >= LIM) begin
                            rel_n   = '0;
                            state_n = ST_IDLE;
                        end else begin
                            rel_n = rel_q + AW'(1);
                        end
                    end else begin
                        rel_n = '0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Outputs follow the eval-cycle decision combinationally so the event,
    // its code and the held/error flags all appear on the eval cycle itself.
    assign kp.key_valid    = accept;
    assign kp.key_code     = code_n;
    assign kp.key_held     = (state_n == ST_PRESSED);
    assign kp.multiple_err = err_n;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

    logic        clk_50mhz = 1'b0;
    logic        init_pulse = 1'b1;
    logic [15:0] pressed = 16'h0;
    int          errors = 0;
    int          checks = 0;
    int          nvalid = 0;

    keypad_scanner_if kp ();

    keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(2)) dut (
        .clk_50mhz  (clk_50mhz),
        .init_pulse (init_pulse),
        .kp         (kp.master)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    // Keypad model: row r pulled low when a pressed key in a driven-low column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            kp.rows_i[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kp.columns_o[c]) kp.rows_i[r] = 1'b0;
            end
        end
    end

    always @(negedge clk_50mhz) begin
        if (kp.key_valid) nvalid++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait for the eval cycle (columns wrap 0111 -> 1110), then settle 1 time unit.
    task automatic next_eval();
        int k;
        k = 0;
        while (kp.columns_o != 4'b0111 && k < 200) begin
            @(negedge clk_50mhz);
            k++;
        end
        while (kp.columns_o != 4'b1110 && k < 200) begin
            @(negedge clk_50mhz);
            k++;
        end
        if (k >= 200) chk("eval_timeout", k, 0);
        #1;
    endtask

    typedef struct {
        logic [15:0] mask;
        int          frames;
        int          valid_now;
        int          count;
        int          code;
        int          held;
        int          err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int k;
        int base;

        vecs[0] = '{16'h0200, 1, 0, 0, 0, 0, 0};  // r2c1 first frame: debounce
        vecs[1] = '{16'h0200, 1, 1, 1, 9, 1, 0};  // second agreeing frame: accept
        vecs[2] = '{16'h0200, 2, 0, 1, 9, 1, 0};  // held: no repeat
        vecs[3] = '{16'h0000, 1, 0, 1, 9, 1, 0};  // one empty frame
        vecs[4] = '{16'h0200, 1, 0, 1, 9, 1, 0};  // re-press: no event
        vecs[5] = '{16'h0000, 2, 0, 1, 9, 0, 0};  // released at 2nd empty frame
        vecs[6] = '{16'h0009, 1, 0, 1, 9, 0, 1};  // r0c0+r0c3: multi-key
        vecs[7] = '{16'h0001, 1, 0, 1, 9, 0, 0};  // r0c0 alone: error clears
        vecs[8] = '{16'h0001, 1, 1, 2, 0, 1, 0};  // r0c0 accepted
        vecs[9] = '{16'h0000, 2, 0, 2, 0, 0, 0};  // release

        // Reset state and first column step.
        repeat (2) @(posedge clk_50mhz);
        #1 init_pulse = 1'b0;
        chk("rst_columns", int'(kp.columns_o), 4'b1110);
        chk("rst_valid", int'(kp.key_valid), 0);
        chk("rst_code", int'(kp.key_code), 0);
        chk("rst_held", int'(kp.key_held), 0);
        chk("rst_err", int'(kp.multiple_err), 0);
        k = 0;
        while (kp.columns_o == 4'b1110 && k < 20) begin
            @(posedge clk_50mhz);
            #1;
            k++;
        end
        chk("col_step_cycles", k, 8);
        chk("col_step_value", int'(kp.columns_o), 4'b1101);

        next_eval();
        for (int i = 0; i < 10; i++) begin
            pressed = vecs[i].mask;
            for (int f = 0; f < vecs[i].frames; f++) next_eval();
            chk($sformatf("v%0d_valid", i), int'(kp.key_valid), vecs[i].valid_now);
            chk($sformatf("v%0d_count", i), nvalid, vecs[i].count);
            chk($sformatf("v%0d_code", i), int'(kp.key_code), vecs[i].code);
            chk($sformatf("v%0d_held", i), int'(kp.key_held), vecs[i].held);
            chk($sformatf("v%0d_err", i), int'(kp.multiple_err), vecs[i].err);
        end

        // Bounce: r1c2 toggles every 5 cycles for about a frame, then stable.
        base = nvalid;
        for (int t = 0; t < 7; t++) begin
            pressed = pressed ^ 16'h0040;
            repeat (5) @(posedge clk_50mhz);
        end
        pressed = 16'h0040;
        repeat (5) next_eval();
        chk("bounce_count", nvalid, base + 1);
        chk("bounce_code", int'(kp.key_code), 6);
        chk("bounce_held", int'(kp.key_held), 1);
        pressed = 16'h0000;
        repeat (3) next_eval();

        // init_pulse while a key is held: re-detected as a new press.
        pressed = 16'h8000;
        repeat (3) next_eval();
        base = nvalid;
        chk("pre_init_count", base, 4);
        init_pulse = 1'b1;
        @(posedge clk_50mhz);
        #1 init_pulse = 1'b0;
        chk("init_columns", int'(kp.columns_o), 4'b1110);
        chk("init_code", int'(kp.key_code), 0);
        chk("init_held", int'(kp.key_held), 0);
        chk("init_err", int'(kp.multiple_err), 0);
        next_eval();
        chk("init_no_early", nvalid, base);
        next_eval();
        chk("init_valid", int'(kp.key_valid), 1);
        chk("init_count", nvalid, base + 1);
        chk("init_recode", int'(kp.key_code), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
